fini_round_ctrl: RTL and testbench

- Sequencer and fault-response controller for a replicated (k=2, three-copy) GF(2) multiply datapath with its consistency detector.
- Loads replicated operands and iterates the shared datapath for ROUNDS cycles, feeding each product back as the next A operand.
- Samples the detector's all-copies-agree flag every round.
- On a mismatch: aborts, zeroizes the result, latches a sticky fault and counts the event.

---
 rtl/fini_round_ctrl.sv | 110 +++++++++++
 tb/tb_fini_round_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fini_round_ctrl.sv
// Round sequencer and fault-response controller for a replicated GF(2) multiply datapath.
// Iterates the datapath ROUNDS times and zeroizes the result if the consistency detector ever disagrees.
module fini_round_ctrl #(
    parameter int REP    = 3,
    parameter int W      = 1,
    parameter int ROUNDS = 4,
    parameter int CNTW   = 8
) (
    input  logic                port_clk,
    input  logic                port_rst,
    input  logic                port_start,
    output logic                port_ready,
    input  logic [REP*W-1:0]    port_a_in,
    input  logic [REP*W-1:0]    port_b_in,
    output logic [REP*W-1:0]    port_dp_a,
    output logic [REP*W-1:0]    port_dp_b,
    input  logic [REP*W-1:0]    port_dp_c,
    input  logic                port_dp_ok,
    output logic [REP*W-1:0]    port_c,
    output logic                port_valid,
    input  logic                port_ack,
    output logic                port_fault,
    input  logic                port_clr_fault,
    output logic [CNTW-1:0]     port_fault_cnt,
    output logic [1:0]          port_dbg_state
);

    localparam int CW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
    localparam logic [CW-1:0] LAST = CW'(ROUNDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DONE  = 2'd2,
        ST_ABORT = 2'd3
    } state_t;

    state_t            state;
    logic [REP*W-1:0]  sreg;
    logic [REP*W-1:0]  breg;
    logic [CW-1:0]     cnt;
    logic              fault;
    logic [CNTW-1:0]   fault_cnt;

    // Handshakes: a job is accepted on an edge where start=1 and ready=1; a
    // result/abort is held while valid=1 and retired on the edge where ack=1.
    always_ff @(posedge port_clk or posedge port_rst) begin
        if (port_rst) begin
            state     <= ST_IDLE;
            sreg      <= '0;
            breg      <= '0;
            cnt       <= '0;
            fault     <= 1'b0;
            fault_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // Clearing takes priority so a start cannot slip in on the same edge.
                    if (port_clr_fault) begin
                        fault <= 1'b0;
                    end else if (port_start && !fault) begin
                        sreg  <= port_a_in;
                        breg  <= port_b_in;
                        cnt   <= '0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (port_dp_ok) begin
                        sreg <= port_dp_c;
                        cnt  <= cnt + 1'b1;
                        if (cnt == LAST) begin
                            state <= ST_DONE;
                        end
                    end else begin
                        sreg  <= '0;
                        fault <= 1'b1;
                        if (fault_cnt != {CNTW{1'b1}}) begin
                            fault_cnt <= fault_cnt + 1'b1;
                        end
                        state <= ST_ABORT;
                    end
                end
                ST_DONE: begin
                    if (port_ack) begin
                        sreg  <= '0;
                        state <= ST_IDLE;
                    end
                end
                ST_ABORT: begin
                    if (port_ack) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Outputs decode only registered state, keeping dp_ok off every output path.
    assign port_ready     = (state == ST_IDLE) && !fault;
    assign port_dp_a      = (state == ST_RUN) ? sreg : '0;
    assign port_dp_b      = (state == ST_RUN) ? breg : '0;
    assign port_valid     = (state == ST_DONE) || (state == ST_ABORT);
    assign port_c         = (state == ST_DONE) ? sreg : '0;
    assign port_fault     = fault;
    assign port_fault_cnt = fault_cnt;
    assign port_dbg_state = state;

endmodule

// File: tb/tb_fini_round_ctrl.sv
// Bench for fini_round_ctrl: AND datapath with a copy-agreement detector, a queue
// scoreboard fed by a job-level reference model, and a decoupled result monitor.
module tb_fini_round_ctrl;

    localparam int REP    = 3;
    localparam int W      = 1;
    localparam int ROUNDS = 4;
    localparam int CNTW   = 8;
    localparam int N      = REP * W;
    localparam int EW     = N + 1 + CNTW;

    logic            clk;
    logic            rst;
    logic            start;
    logic            ready;
    logic [N-1:0]    a_in;
    logic [N-1:0]    b_in;
    logic [N-1:0]    dp_a;
    logic [N-1:0]    dp_b;
    logic [N-1:0]    dp_c;
    logic            dp_ok;
    logic [N-1:0]    c;
    logic            valid;
    logic            ack;
    logic            fault;
    logic            clr_fault;
    logic [CNTW-1:0] fault_cnt;
    logic [1:0]      dbg_state;
    logic            force_bad;

    int n_checks = 0;
    int n_pass   = 0;
    logic [EW-1:0] exp_q[$];

    logic            m_fault;
    logic [CNTW-1:0] m_cnt;
    logic            prev_valid;

    fini_round_ctrl #(.REP(REP), .W(W), .ROUNDS(ROUNDS), .CNTW(CNTW)) dut (
        .port_clk       (clk),
        .port_rst       (rst),
        .port_start     (start),
        .port_ready     (ready),
        .port_a_in      (a_in),
        .port_b_in      (b_in),
        .port_dp_a      (dp_a),
        .port_dp_b      (dp_b),
        .port_dp_c      (dp_c),
        .port_dp_ok     (dp_ok),
        .port_c         (c),
        .port_valid     (valid),
        .port_ack       (ack),
        .port_fault     (fault),
        .port_clr_fault (clr_fault),
        .port_fault_cnt (fault_cnt),
        .port_dbg_state (dbg_state)
    );

    // Bench datapath: bitwise AND per copy; detector flags agreement of all copies.
    assign dp_c  = dp_a & dp_b;
    assign dp_ok = ((dp_c == '0) || (dp_c == '1)) && !force_bad;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached (actual=running required=finished)");
        $fatal(1, "watchdog");
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    endtask

    // Job-level reference: iterate s <- s & b; any disagreement or forced round aborts.
    function automatic logic [N-1:0] ref_result(input logic [N-1:0] a, input logic [N-1:0] b,
                                                input int bad, output logic aborted);
        logic [N-1:0] s;
        logic [N-1:0] p;
        s = a;
        aborted = 1'b0;
        for (int r = 1; r <= ROUNDS; r++) begin
            p = s & b;
            if (!((p == '0) || (p == '1)) || (r == bad)) begin
                aborted = 1'b1;
                return '0;
            end
            s = p;
        end
        return s;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_valid", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_c", c, e[EW-1 -: N]);
                    chk("sb_fault", fault, e[CNTW]);
                    chk("sb_fault_cnt", fault_cnt, e[CNTW-1:0]);
                end
            end
            if (!valid) chk("c_zero_when_idle", c, '0);
            prev_valid = valid;
        end
    end

    // ---------------- driver ----------------
    task automatic run_job(input logic [N-1:0] a, input logic [N-1:0] b, input int bad, input int hold);
        logic ab;
        logic [N-1:0] ec;
        int n;
        if (m_fault) begin
            @(posedge clk); #1 clr_fault = 1'b1; start = 1'b1;
            @(posedge clk); #1 clr_fault = 1'b0; start = 1'b0;
            @(negedge clk);
            chk("clr_fault_flag", fault, 0);
            chk("clr_start_ignored", dbg_state, 0);
            m_fault = 1'b0;
        end
        n = 0;
        @(negedge clk);
        while (!ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("ready_timeout", ready, 1);
        ec = ref_result(a, b, bad, ab);
        if (ab) begin
            m_fault = 1'b1;
            if (m_cnt != '1) m_cnt = m_cnt + 1'b1;
        end
        exp_q.push_back({ec, m_fault, m_cnt});
        @(posedge clk); #1 a_in = a; b_in = b; start = 1'b1;
        @(posedge clk); #1 start = 1'b0; force_bad = (bad == 1);
        @(negedge clk);
        chk("run_entered", dbg_state, 1);
        chk("round1_dp_a", dp_a, a);
        chk("round1_dp_b", dp_b, b);
        for (int r = 2; r <= ROUNDS; r++) begin
            @(posedge clk); #1 force_bad = (bad == r);
        end
        @(posedge clk); #1 force_bad = 1'b0;
        n = 0;
        @(negedge clk);
        while (!valid && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk("valid_timeout", valid, 1);
        for (int h = 0; h < hold; h++) begin
            chk("hold_valid", valid, 1);
            chk("hold_c", c, ec);
            @(negedge clk);
        end
        @(posedge clk); #1 ack = 1'b1;
        @(posedge clk); #1 ack = 1'b0;
        @(negedge clk);
        chk("after_ack_idle", dbg_state, 0);
        chk("after_ack_ready", ready, !m_fault);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [N-1:0] ra;
        logic [N-1:0] rb;
        int bad;
        rst = 1'b1; start = 1'b0; ack = 1'b0; clr_fault = 1'b0;
        a_in = '0; b_in = '0; force_bad = 1'b0;
        m_fault = 1'b0; m_cnt = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_state", dbg_state, 0);
        chk("rst_ready", ready, 1);
        chk("rst_valid", valid, 0);
        chk("rst_fault", fault, 0);
        chk("rst_fault_cnt", fault_cnt, 0);
        chk("rst_dp_a", dp_a, 0);

        // Asynchronous reset while the job is in round 2.
        @(posedge clk); #1 a_in = 3'b111; b_in = 3'b111; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        chk("mid_r1_dp_a", dp_a, 3'b111);
        @(posedge clk); #2 rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_state", dbg_state, 0);
        chk("mid_rst_ready", ready, 1);
        chk("mid_rst_valid", valid, 0);
        chk("mid_rst_dp_a", dp_a, 0);
        chk("mid_rst_dp_b", dp_b, 0);
        chk("mid_rst_fault_cnt", fault_cnt, 0);
        @(posedge clk); #1 rst = 1'b0;

        run_job(3'b111, 3'b111, 0, 2);
        run_job(3'b111, 3'b000, 0, 1);
        run_job(3'b111, 3'b111, 2, 1);

        // Sticky fault blocks a plain start.
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        chk("fault_start_ignored", dbg_state, 0);
        chk("fault_ready_low", ready, 0);
        chk("fault_sticky", fault, 1);

        run_job(3'b111, 3'b111, 0, 10);

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                ra = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'b111;
                rb = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'b111;
            end else begin
                ra = N'($urandom_range(0, 7));
                rb = N'($urandom_range(0, 7));
            end
            bad = ($urandom_range(0, 3) == 0) ? $urandom_range(1, ROUNDS) : 0;
            run_job(ra, rb, bad, $urandom_range(0, 3));
        end

        for (int i = 0; i < 260; i++) begin
            run_job(N'($urandom_range(0, 7)), N'($urandom_range(0, 7)), $urandom_range(1, ROUNDS), 0);
        end
        chk("sat_fault_cnt", fault_cnt, 255);
        chk("sat_model_cnt", fault_cnt, m_cnt);

        repeat (3) @(negedge clk);
        chk("sb_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
